chebyshev_poly_eval: RTL and testbench
======================================

Name: chebyshev_poly_eval

Overview:
- Sequential fixed-point evaluator of a polynomial of parametrised degree, one multiply-add step every two cycles.
- Two modes, selected per sample:
  - power series by Horner, p(x)=sum c_k x^k;
  - Chebyshev series by Clenshaw, f(x)=sum c_k T_k(x).
- Coefficients live in an internal register file written through a side port.
- Samples enter and results leave through valid/ready handshakes, for use as the activation/approximation unit between datapath stages.

Parameters:
- WORD_LENGTH, 16, width of input x; signed Q1.(WORD_LENGTH-1).
- COEFF_LENGTH, 16, width of coefficients and of data_out; signed.
- COEFF_FRAC, 12, fractional bits of coefficients, accumulator and data_out.
- DEGREE, 2, polynomial degree N (>=1); N+1 coefficients.
- WIDENING, 2, accumulator guard bits; ACC_LENGTH = COEFF_LENGTH+WIDENING.
- Derived (not overridable): ADDR_W = max(1, clog2(DEGREE+1)).

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block idle; a sample is accepted when in_valid&&in_ready.
- data_in  in  WORD_LENGTH  x.
- mode_in  in  1  0=Horner, 1=Clenshaw; sampled with data_in.
- coeff_wr_en  in  1  coefficient write strobe.
- coeff_wr_addr  in  ADDR_W  coefficient index k.
- coeff_wr_data  in  COEFF_LENGTH  c_k.
- coeff_wr_ignored  out  1  one-cycle pulse: last write was dropped.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- data_out  out  COEFF_LENGTH  result, saturated.
- ovf_out  out  1  saturation occurred during this result; valid with out_valid.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; in_ready=1; out_valid=0; data_out=0; ovf_out=0; coeff_wr_ignored=0.
  - All coefficients, acc, b2 and product registers cleared to 0.
  - Reset mid-computation aborts the computation; no result is emitted.
- FSM states: IDLE, MUL, ADD, DONE.
  - IDLE: in_ready=1. On accept: latch x and mode, acc=0, b2=0, k=DEGREE, ovf=0, go to MUL.
  - MUL: prod <= acc*x (full ACC_LENGTH+WORD_LENGTH signed), then go to ADD.
  - ADD:
    - shift S = WORD_LENGTH-2 when (mode=1 and k>0), else S = WORD_LENGTH-1 (the S = WORD_LENGTH-2 case implements the 2x term).
    - r = (prod + 2^(S-1)) >>> S (round half up).
    - sum = r + sext(c_k) - (mode ? b2 : 0).
    - b2 <= acc; acc <= sat_ACC(sum); set ovf if saturated.
    - If k==0 go to DONE, else k--, go to MUL.
  - DONE: out_valid=1; data_out=sat_COEFF(acc), with ovf |= saturated; hold stable until out_ready. Then go to IDLE (out_valid=0).
- No accept in the same cycle as the result handshake; one idle cycle between results.
- Latency: out_valid rises 2*(DEGREE+1) cycles after the accept edge (6 for DEGREE=2).
- Throughput: one result per 2*DEGREE+4 cycles with out_ready held high.
- Saturation clamps to the most positive/negative representable value of the target width, never wraps.
- Coefficient writes:
  - Committed on the clock edge only when state==IDLE and coeff_wr_addr<=DEGREE.
  - Otherwise dropped, with coeff_wr_ignored=1 on the next cycle.
  - A write in the same IDLE cycle as a sample accept is committed and used by that sample.
- Simultaneous coeff write and reset: reset wins.
- in_valid while busy has no effect; data_in and mode_in are don't-care.

Test Plan (DEGREE=2, WORD_LENGTH=16, COEFF_LENGTH=16, COEFF_FRAC=12, WIDENING=2; c0=0x0800, c1=0x0400, c2=0x1000):
- Horner: x=0x4000 (0.5), mode 0 -> out_valid 6 cycles after accept, data_out=0x0E00 (0.875), ovf_out=0.
- Clenshaw: x=0x4000, mode 1 -> data_out=0x0200 (0.125 = 0.5*T0+0.25*T1+1.0*T2), ovf_out=0; intermediate b2 reaches 0x1400 (1.25).
- Saturation: all c_k=0x7FFF, x=0x7FFF, mode 0 -> data_out=0x7FFF, ovf_out=1; next sample with the default coefficients gives ovf_out=0.
- Backpressure: out_ready low for 5 cycles after out_valid -> data_out/out_valid stable, in_ready=0, a pulse on in_valid not accepted. out_ready=1 -> IDLE next cycle, in_ready=1.
- Coefficient protection:
  - Write c1=0x7000 during MUL -> coeff_wr_ignored pulses one cycle, result still 0x0E00.
  - Write to addr 3 in IDLE -> ignored pulse.
  - Same-cycle write c0=0x0000 with accept -> Horner result 0x0600.
- Reset in ADD of the 2nd step -> out_valid=0, in_ready=1, coefficients 0. Subsequent Horner x=0x4000 -> data_out=0x0000.

Source files
------------

// File: rtl/chebyshev_poly_eval_if.sv
// Sample, result and coefficient-write signals of chebyshev_poly_eval.
// The master side is the producer/consumer; the slave side is the evaluator.
interface chebyshev_poly_eval_if #(
    parameter int WORD_LENGTH  = 16,
    parameter int COEFF_LENGTH = 16,
    parameter int DEGREE       = 2
);
    localparam int ADDR_W = ($clog2(DEGREE + 1) > 1) ? $clog2(DEGREE + 1) : 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [WORD_LENGTH-1:0]  data_in;
    logic                    mode_in;
    logic                    coeff_wr_en;
    logic [ADDR_W-1:0]       coeff_wr_addr;
    logic [COEFF_LENGTH-1:0] coeff_wr_data;
    logic                    coeff_wr_ignored;
    logic                    out_valid;
    logic                    out_ready;
    logic [COEFF_LENGTH-1:0] data_out;
    logic                    ovf_out;

    modport master (
        output in_valid, data_in, mode_in, coeff_wr_en, coeff_wr_addr, coeff_wr_data, out_ready,
        input  in_ready, coeff_wr_ignored, out_valid, data_out, ovf_out
    );

    modport slave (
        input  in_valid, data_in, mode_in, coeff_wr_en, coeff_wr_addr, coeff_wr_data, out_ready,
        output in_ready, coeff_wr_ignored, out_valid, data_out, ovf_out
    );
endinterface

// File: rtl/chebyshev_poly_eval.sv
// Sequential fixed-point polynomial evaluator: Horner (power series) or Clenshaw
// (Chebyshev series), one multiply-add step per MUL/ADD state pair.
module chebyshev_poly_eval #(
    parameter int WORD_LENGTH  = 16,
    parameter int COEFF_LENGTH = 16,
    parameter int COEFF_FRAC   = 12,
    parameter int DEGREE       = 2,
    parameter int WIDENING     = 2
) (
    input  logic                 clock,
    input  logic                 resetn,
    chebyshev_poly_eval_if.slave bus
);
    localparam int ADDR_W     = ($clog2(DEGREE + 1) > 1) ? $clog2(DEGREE + 1) : 1;
    localparam int ACC_LENGTH = COEFF_LENGTH + WIDENING;
    localparam int PROD_W     = ACC_LENGTH + WORD_LENGTH;
    localparam int SUM_W      = PROD_W + 2;

    // Rounding constants 2^(S-1) for S = WORD_LENGTH-1 and S = WORD_LENGTH-2.
    localparam logic signed [SUM_W-1:0] HALF_X1 =
        {{(SUM_W - WORD_LENGTH + 1){1'b0}}, 1'b1, {(WORD_LENGTH - 2){1'b0}}};
    localparam logic signed [SUM_W-1:0] HALF_X2 =
        {{(SUM_W - WORD_LENGTH + 2){1'b0}}, 1'b1, {(WORD_LENGTH - 3){1'b0}}};

    localparam logic [ACC_LENGTH-1:0]   ACC_MAX   = {1'b0, {(ACC_LENGTH - 1){1'b1}}};
    localparam logic [ACC_LENGTH-1:0]   ACC_MIN   = {1'b1, {(ACC_LENGTH - 1){1'b0}}};
    localparam logic [COEFF_LENGTH-1:0] COEFF_MAX = {1'b0, {(COEFF_LENGTH - 1){1'b1}}};
    localparam logic [COEFF_LENGTH-1:0] COEFF_MIN = {1'b1, {(COEFF_LENGTH - 1){1'b0}}};

    if (DEGREE < 1 || WORD_LENGTH < 3 || COEFF_FRAC >= COEFF_LENGTH) begin : g_bad_params
        $error("chebyshev_poly_eval: unsupported parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StMul, StAdd, StDone} state_e;

    state_e                         r_state;
    state_e                         w_state_next;
    logic                           w_in_ready;
    logic                           w_out_valid;
    logic                           w_accept;

    logic signed [WORD_LENGTH-1:0]  r_x;
    logic                           r_mode;
    logic [ADDR_W-1:0]              r_k;
    logic signed [ACC_LENGTH-1:0]   r_acc;
    logic signed [ACC_LENGTH-1:0]   r_b2;
    logic signed [PROD_W-1:0]       r_prod;
    logic                           r_ovf;
    logic [COEFF_LENGTH-1:0]        r_data_out;
    logic                           r_ovf_out;
    logic                           r_wr_ignored;
    logic signed [COEFF_LENGTH-1:0] r_coef [DEGREE+1];

    logic                           w_wr_ok;
    logic signed [PROD_W-1:0]       w_acc_ext;
    logic signed [PROD_W-1:0]       w_x_ext;
    logic signed [SUM_W-1:0]        w_prod_ext;
    logic signed [SUM_W-1:0]        w_rnd_x1;
    logic signed [SUM_W-1:0]        w_rnd_x2;
    logic                           w_dbl;
    logic signed [COEFF_LENGTH-1:0] w_coef_sel;
    logic signed [SUM_W-1:0]        w_coef_ext;
    logic signed [SUM_W-1:0]        w_b2_ext;
    logic signed [SUM_W-1:0]        w_sum;
    logic [SUM_W-ACC_LENGTH:0]      w_sum_hi;
    logic                           w_acc_sat;
    logic [ACC_LENGTH-1:0]          w_acc_next;
    logic [ACC_LENGTH-COEFF_LENGTH:0] w_out_hi;
    logic                           w_out_sat;
    logic [COEFF_LENGTH-1:0]        w_out_val;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = StMul;
                end
            end
            StMul: w_state_next = StAdd;
            StAdd: w_state_next = (r_k == '0) ? StDone : StMul;
            StDone: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_accept = w_in_ready & bus.in_valid;

    // ----------------------------------------------------------- datapath
    assign w_acc_ext  = {{WORD_LENGTH{r_acc[ACC_LENGTH-1]}}, r_acc};
    assign w_x_ext    = {{ACC_LENGTH{r_x[WORD_LENGTH-1]}}, r_x};
    assign w_prod_ext = {{2{r_prod[PROD_W-1]}}, r_prod};
    assign w_rnd_x1   = (w_prod_ext + HALF_X1) >>> (WORD_LENGTH - 1);
    assign w_rnd_x2   = (w_prod_ext + HALF_X2) >>> (WORD_LENGTH - 2);
    // Clenshaw inner steps use 2*x*b1, folded into one less bit of shift.
    assign w_dbl      = r_mode && (r_k != '0);

    assign w_coef_sel = r_coef[r_k];
    assign w_coef_ext = {{(SUM_W - COEFF_LENGTH){w_coef_sel[COEFF_LENGTH-1]}}, w_coef_sel};
    assign w_b2_ext   = r_mode ? {{(SUM_W - ACC_LENGTH){r_b2[ACC_LENGTH-1]}}, r_b2} : '0;
    assign w_sum      = (w_dbl ? w_rnd_x2 : w_rnd_x1) + w_coef_ext - w_b2_ext;

    assign w_sum_hi   = w_sum[SUM_W-1:ACC_LENGTH-1];
    assign w_acc_sat  = !((&w_sum_hi) || !(|w_sum_hi));
    assign w_acc_next = w_acc_sat ? (w_sum[SUM_W-1] ? ACC_MIN : ACC_MAX)
                                  : w_sum[ACC_LENGTH-1:0];

    assign w_out_hi   = w_acc_next[ACC_LENGTH-1:COEFF_LENGTH-1];
    assign w_out_sat  = !((&w_out_hi) || !(|w_out_hi));
    assign w_out_val  = w_out_sat ? (w_acc_next[ACC_LENGTH-1] ? COEFF_MIN : COEFF_MAX)
                                  : w_acc_next[COEFF_LENGTH-1:0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_x        <= '0;
            r_mode     <= 1'b0;
            r_k        <= '0;
            r_acc      <= '0;
            r_b2       <= '0;
            r_prod     <= '0;
            r_ovf      <= 1'b0;
            r_data_out <= '0;
            r_ovf_out  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x    <= bus.data_in;
                r_mode <= bus.mode_in;
                r_acc  <= '0;
                r_b2   <= '0;
                r_k    <= ADDR_W'(DEGREE);
                r_ovf  <= 1'b0;
            end
            if (r_state == StMul) begin
                r_prod <= w_acc_ext * w_x_ext;
            end
            if (r_state == StAdd) begin
                r_b2  <= r_acc;
                r_acc <= w_acc_next;
                r_ovf <= r_ovf | w_acc_sat;
                if (r_k == '0) begin
                    // Result is registered on the way into DONE so it is stable there.
                    r_data_out <= w_out_val;
                    r_ovf_out  <= r_ovf | w_acc_sat | w_out_sat;
                end else begin
                    r_k <= r_k - ADDR_W'(1);
                end
            end
        end
    end

    // ---------------------------------------------------- coefficient file
    assign w_wr_ok = bus.coeff_wr_en && (r_state == StIdle) &&
                     (bus.coeff_wr_addr <= ADDR_W'(DEGREE));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i <= DEGREE; i++) begin
                r_coef[i] <= '0;
            end
            r_wr_ignored <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_coef[bus.coeff_wr_addr] <= bus.coeff_wr_data;
            end
            r_wr_ignored <= bus.coeff_wr_en && !w_wr_ok;
        end
    end

    assign bus.in_ready         = w_in_ready;
    assign bus.out_valid        = w_out_valid;
    assign bus.data_out         = r_data_out;
    assign bus.ovf_out          = r_ovf_out;
    assign bus.coeff_wr_ignored = r_wr_ignored;
endmodule

// File: tb/tb_chebyshev_poly_eval.sv
// Directed bench for chebyshev_poly_eval: Horner, Clenshaw, saturation,
// back-to-back throughput, backpressure, coefficient protection and mid-run reset.
module tb_chebyshev_poly_eval;
    localparam int WL = 16;
    localparam int CL = 16;
    localparam int CF = 12;
    localparam int DG = 2;
    localparam int WD = 2;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clock = ~clock;

    chebyshev_poly_eval_if #(.WORD_LENGTH(WL), .COEFF_LENGTH(CL), .DEGREE(DG)) bus ();

    chebyshev_poly_eval #(
        .WORD_LENGTH (WL),
        .COEFF_LENGTH(CL),
        .COEFF_FRAC  (CF),
        .DEGREE      (DG),
        .WIDENING    (WD)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    task automatic wr_coef(input logic [1:0] a, input logic [15:0] d);
        @(negedge clock);
        bus.coeff_wr_en   = 1'b1;
        bus.coeff_wr_addr = a;
        bus.coeff_wr_data = d;
        @(negedge clock);
        bus.coeff_wr_en   = 1'b0;
    endtask

    task automatic load_defaults();
        wr_coef(2'd0, 16'h0800);
        wr_coef(2'd1, 16'h0400);
        wr_coef(2'd2, 16'h1000);
    endtask

    // Waits at most 40 cycles for out_valid; lat counts cycles from the accept edge.
    task automatic run_sample(input logic [15:0] x, input logic m,
                              output logic [15:0] res, output logic ovf, output int lat);
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.data_in  = x;
        bus.mode_in  = m;
        @(negedge clock);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        res = bus.data_out;
        ovf = bus.ovf_out;
    endtask

    task automatic wait_result(output int cnt);
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 40) begin
            @(negedge clock);
            cnt++;
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.data_in = '0; bus.mode_in = 1'b0; bus.out_ready = 1'b1;
        bus.coeff_wr_en = 1'b0; bus.coeff_wr_addr = '0; bus.coeff_wr_data = '0;
        resetn = 1'b0;
        #23;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else n_pass++;
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        else n_pass++;
        n_total++;
        if (bus.data_out !== 16'h0000) $display("FAIL reset_data_out: got %h want 0000", bus.data_out);
        else n_pass++;
        n_total++;
        if (bus.ovf_out !== 1'b0) $display("FAIL reset_ovf_out: got %b want 0", bus.ovf_out);
        else n_pass++;
        n_total++;
        if (bus.coeff_wr_ignored !== 1'b0)
            $display("FAIL reset_wr_ignored: got %b want 0", bus.coeff_wr_ignored);
        else n_pass++;
    endtask

    task automatic test_horner();
        logic [15:0] res; logic ovf; int lat;
        run_sample(16'h4000, 1'b0, res, ovf, lat);
        n_total++;
        if (lat !== 6) $display("FAIL horner_latency: got %0d want 6", lat); else n_pass++;
        n_total++;
        if (res !== 16'h0E00) $display("FAIL horner_data: got %h want 0e00", res); else n_pass++;
        n_total++;
        if (ovf !== 1'b0) $display("FAIL horner_ovf: got %b want 0", ovf); else n_pass++;
    endtask

    task automatic test_clenshaw();
        logic [15:0] res; logic ovf; int lat;
        run_sample(16'h4000, 1'b1, res, ovf, lat);
        n_total++;
        if (lat !== 6) $display("FAIL clenshaw_latency: got %0d want 6", lat); else n_pass++;
        n_total++;
        if (res !== 16'h0200) $display("FAIL clenshaw_data: got %h want 0200", res); else n_pass++;
        n_total++;
        if (ovf !== 1'b0) $display("FAIL clenshaw_ovf: got %b want 0", ovf); else n_pass++;
        n_total++;
        if (dut.r_b2 !== 18'sh01400) $display("FAIL clenshaw_b2: got %h want 01400", dut.r_b2);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [15:0] res; logic ovf; int lat;
        wr_coef(2'd0, 16'h7FFF);
        wr_coef(2'd1, 16'h7FFF);
        wr_coef(2'd2, 16'h7FFF);
        run_sample(16'h7FFF, 1'b0, res, ovf, lat);
        n_total++;
        if (res !== 16'h7FFF) $display("FAIL sat_data: got %h want 7fff", res); else n_pass++;
        n_total++;
        if (ovf !== 1'b1) $display("FAIL sat_ovf: got %b want 1", ovf); else n_pass++;
        load_defaults();
        run_sample(16'h4000, 1'b0, res, ovf, lat);
        n_total++;
        if (res !== 16'h0E00) $display("FAIL sat_recover_data: got %h want 0e00", res); else n_pass++;
        n_total++;
        if (ovf !== 1'b0) $display("FAIL sat_recover_ovf: got %b want 0", ovf); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        int nres = 0;
        @(negedge clock);
        bus.in_valid = 1'b1; bus.data_in = 16'h4000; bus.mode_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready === 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (bus.out_valid === 1'b1) begin
                nres++;
                n_total++;
                if (bus.data_out !== 16'h0E00)
                    $display("FAIL b2b_data: got %h want 0e00", bus.data_out);
                else n_pass++;
            end
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready === 1'b1 && bus.out_valid === 1'b0) break;
            @(negedge clock);
        end
        n_total++;
        if (second - first !== 8) $display("FAIL b2b_interval: got %0d want 8", second - first);
        else n_pass++;
        n_total++;
        if (nres !== 2) $display("FAIL b2b_results: got %0d want 2", nres); else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL b2b_drain: got %b want 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [15:0] res; logic ovf; int lat;
        logic quiet;
        bus.out_ready = 1'b0;
        run_sample(16'h4000, 1'b0, res, ovf, lat);
        n_total++;
        if (res !== 16'h0E00 || lat !== 6)
            $display("FAIL bp_first: got %h lat %0d want 0e00 lat 6", res, lat);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i == 2);
            bus.data_in  = 16'h1111;
            @(negedge clock);
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.data_out !== 16'h0E00 || bus.in_ready !== 1'b0)
                $display("FAIL bp_hold: got valid %b data %h ready %b want 1 0e00 0",
                         bus.out_valid, bus.data_out, bus.in_ready);
            else n_pass++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clock);
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL bp_release: got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready);
        else n_pass++;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) quiet = 1'b0;
        end
        n_total++;
        if (quiet !== 1'b1) $display("FAIL bp_no_accept: got %b want 1", quiet); else n_pass++;
    endtask

    task automatic test_coeff_protect();
        int cnt;
        logic [15:0] res; logic ovf; int lat;
        // Write attempted while busy.
        @(negedge clock);
        bus.in_valid = 1'b1; bus.data_in = 16'h4000; bus.mode_in = 1'b0;
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.coeff_wr_en = 1'b1; bus.coeff_wr_addr = 2'd1; bus.coeff_wr_data = 16'h7000;
        @(negedge clock);
        bus.coeff_wr_en = 1'b0;
        n_total++;
        if (bus.coeff_wr_ignored !== 1'b1)
            $display("FAIL busy_wr_pulse: got %b want 1", bus.coeff_wr_ignored);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if (bus.coeff_wr_ignored !== 1'b0)
            $display("FAIL busy_wr_pulse_end: got %b want 0", bus.coeff_wr_ignored);
        else n_pass++;
        wait_result(cnt);
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.data_out !== 16'h0E00)
            $display("FAIL busy_wr_data: got valid %b data %h want 1 0e00",
                     bus.out_valid, bus.data_out);
        else n_pass++;
        // Out-of-range address while idle.
        wr_coef(2'd3, 16'h1234);
        n_total++;
        if (bus.coeff_wr_ignored !== 1'b1)
            $display("FAIL addr3_pulse: got %b want 1", bus.coeff_wr_ignored);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if (bus.coeff_wr_ignored !== 1'b0)
            $display("FAIL addr3_pulse_end: got %b want 0", bus.coeff_wr_ignored);
        else n_pass++;
        run_sample(16'h4000, 1'b0, res, ovf, lat);
        n_total++;
        if (res !== 16'h0E00) $display("FAIL addr3_data: got %h want 0e00", res); else n_pass++;
        // Write in the same cycle as the accept.
        @(negedge clock);
        bus.in_valid = 1'b1; bus.data_in = 16'h4000; bus.mode_in = 1'b0;
        bus.coeff_wr_en = 1'b1; bus.coeff_wr_addr = 2'd0; bus.coeff_wr_data = 16'h0000;
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.coeff_wr_en = 1'b0;
        n_total++;
        if (bus.coeff_wr_ignored !== 1'b0)
            $display("FAIL same_cycle_wr_pulse: got %b want 0", bus.coeff_wr_ignored);
        else n_pass++;
        wait_result(cnt);
        n_total++;
        if (bus.out_valid !== 1'b1 || bus.data_out !== 16'h0600)
            $display("FAIL same_cycle_wr_data: got valid %b data %h want 1 0600",
                     bus.out_valid, bus.data_out);
        else n_pass++;
        load_defaults();
    endtask

    task automatic test_reset_mid();
        logic [15:0] res; logic ovf; int lat;
        logic quiet;
        @(negedge clock);
        bus.in_valid = 1'b1; bus.data_in = 16'h4000; bus.mode_in = 1'b0;
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        #1;
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL midrst_state: got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready);
        else n_pass++;
        @(negedge clock);
        resetn = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus.out_valid !== 1'b0) quiet = 1'b0;
        end
        n_total++;
        if (quiet !== 1'b1) $display("FAIL midrst_no_result: got %b want 1", quiet); else n_pass++;
        run_sample(16'h4000, 1'b0, res, ovf, lat);
        n_total++;
        if (res !== 16'h0000 || lat !== 6)
            $display("FAIL midrst_cleared_coef: got %h lat %0d want 0000 lat 6", res, lat);
        else n_pass++;
        load_defaults();
        run_sample(16'h4000, 1'b0, res, ovf, lat);
        n_total++;
        if (res !== 16'h0E00) $display("FAIL midrst_reload: got %h want 0e00", res); else n_pass++;
    endtask

    initial begin
        test_reset();
        load_defaults();
        test_horner();
        test_clenshaw();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_coeff_protect();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
